// File: rtl/sys_input_skew.sv
// Diagonal staging buffer for the systolic array west edge.
// Lane i is delayed by i extra cycles so the array sees a skewed wavefront.
module sys_input_skew #(
  parameter int data_width   = 8,
  parameter int width_height = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [data_width*width_height-1:0] in_data,
  input  logic [width_height-1:0]            in_en,
  input  logic                               clear,
  output logic [data_width*width_height-1:0] out_data,
  output logic [width_height-1:0]            out_valid,
  output logic                               busy,
  output logic                               drain_done
);

  logic [width_height-1:0] lane_any;
  logic [width_height-1:0] lane_mid;
  logic                    busy_next;
  logic                    drain_done_q;
  logic                    flush;

  assign flush = !reset || clear;

  for (genvar i = 0; i < width_height; i++) begin : g_lane
    // Stage 0 loads the incoming row; stage i drives the lane output.
    logic [i:0]            vld_p;
    logic [data_width-1:0] dat_p [0:i];

    always_ff @(posedge clk) begin
      if (flush) begin
        vld_p <= '0;
        for (int k = 0; k <= i; k++) dat_p[k] <= '0;
      end else begin
        vld_p[0] <= in_en[i];
        dat_p[0] <= in_en[i] ? in_data[i*data_width +: data_width] : '0;
        for (int k = 1; k <= i; k++) begin
          vld_p[k] <= vld_p[k-1];
          dat_p[k] <= dat_p[k-1];
        end
      end
    end

    assign out_valid[i]                          = vld_p[i];
    assign out_data[i*data_width +: data_width]  = dat_p[i];
    assign lane_any[i]                           = |vld_p;

    // Valid bits that will still be stored after the next shift (all but the last stage).
    if (i > 0) begin : g_mid
      assign lane_mid[i] = |vld_p[i-1:0];
    end else begin : g_nomid
      assign lane_mid[i] = 1'b0;
    end
  end

  assign busy      = |lane_any;
  assign busy_next = (|in_en) || (|lane_mid);

  // Pulse when the last valid word leaves; a flush never produces a pulse.
  always_ff @(posedge clk) begin
    if (flush) drain_done_q <= 1'b0;
    else       drain_done_q <= busy && !busy_next;
  end

  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_sys_input_skew.sv
// Randomized and directed bench for sys_input_skew against a row-history model.
module tb_sys_input_skew;
  localparam int DW   = 8;
  localparam int WH   = 4;
  localparam int MAXE = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW*WH-1:0]  in_data;
  logic [WH-1:0]     in_en;
  logic              clear;
  logic [DW*WH-1:0]  out_data;
  logic [WH-1:0]     out_valid;
  logic              busy;
  logic              drain_done;

  sys_input_skew #(.data_width(DW), .width_height(WH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_en(in_en), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  // Row history: what was presented at each edge and the latest flush edge at that point.
  logic [DW*WH-1:0] hd  [MAXE];
  logic [WH-1:0]    he  [MAXE];
  int               lfa [MAXE];
  int               e  = 0;
  int               lf = -1;
  int               total = 0;
  int               bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", tag, e, obs, exp);
    end
  endtask

  // A row accepted at edge m sits somewhere in lane i at edge k iff k-i <= m <= k and no flush since.
  function automatic logic busy_at(int k);
    logic b = 1'b0;
    for (int i = 0; i < WH; i++)
      for (int m = k - i; m <= k; m++)
        if (m >= 0 && m > lfa[k] && he[m][i]) b = 1'b1;
    return b;
  endfunction

  task automatic step(input string tag, input logic [DW*WH-1:0] d, input logic [WH-1:0] en,
                      input logic clr, input logic rst_n);
    logic [DW*WH-1:0] exp_d;
    logic [WH-1:0]    exp_v;
    logic             exp_dd;
    int               m;
    if (e >= MAXE) begin
      $display("FAIL %s history overflow edge=%0d limit=%0d", tag, e, MAXE);
      $fatal(1);
    end
    in_data = d; in_en = en; clear = clr; reset = rst_n;
    hd[e] = d; he[e] = en;
    if (clr || !rst_n) lf = e;
    lfa[e] = lf;
    @(posedge clk); #1;
    exp_d = '0; exp_v = '0;
    for (int i = 0; i < WH; i++) begin
      m = e - i;
      if (m >= 0 && m > lf && he[m][i]) begin
        exp_v[i] = 1'b1;
        exp_d[i*DW +: DW] = hd[m][i*DW +: DW];
      end
    end
    exp_dd = (e > 0) && (lf != e) && busy_at(e - 1) && !busy_at(e);
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_v));
    check({tag, "_data"},  64'(out_data),  64'(exp_d));
    check({tag, "_busy"},  64'(busy),      64'(busy_at(e)));
    check({tag, "_drain"}, 64'(drain_done), 64'(exp_dd));
    e++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_en = '0; in_data = '0;
    step("rst", 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    step("rst", 32'h12345678, 4'b1111, 1'b0, 1'b0);
    check("rst_out_data", 64'(out_data), 64'h0);
    idle("t0", 2);

    // Single full row; lane0 holds the low byte.
    step("t1", 32'h04030201, 4'b1111, 1'b0, 1'b1);
    idle("t1", 6);

    // Four back-to-back rows.
    for (int r = 0; r < 4; r++) step("t2", {4{8'(r + 1)}}, 4'b1111, 1'b0, 1'b1);
    idle("t2", 7);

    // Partial enable.
    step("t3", 32'hDDCCBBAA, 4'b0011, 1'b0, 1'b1);
    idle("t3", 5);

    // Clear in the middle of a stream.
    step("t4", {4{8'h11}}, 4'b1111, 1'b0, 1'b1);
    step("t4", {4{8'h22}}, 4'b1111, 1'b0, 1'b1);
    step("t4", {4{8'h33}}, 4'b1111, 1'b1, 1'b1);
    step("t4", {4{8'h44}}, 4'b1111, 1'b0, 1'b1);
    idle("t4", 7);

    // Clear and enable together on an empty pipe.
    step("t5", 32'hFFEEDDCC, 4'b1111, 1'b1, 1'b1);
    idle("t5", 6);

    // Reset mid-stream, then a fresh row.
    step("t6", {4{8'h01}}, 4'b1111, 1'b0, 1'b1);
    step("t6", {4{8'h02}}, 4'b1111, 1'b0, 1'b1);
    step("t6", {4{8'h03}}, 4'b1111, 1'b0, 1'b0);
    idle("t6", 8);
    step("t6", 32'h04030201, 4'b1111, 1'b0, 1'b1);
    idle("t6", 6);

    // Enable low with live data is discarded.
    step("t7", 32'hA5A5A5A5, 4'b0000, 1'b0, 1'b1);
    idle("t7", 5);

    for (int k = 0; k < 1500; k++) begin
      logic [WH-1:0] en;
      logic          clr, rn;
      en  = (($urandom % 4) == 0) ? '0 : WH'($urandom);
      clr = (($urandom % 20) == 0);
      rn  = (($urandom % 60) != 0);
      step("rnd", DW*WH'($urandom), en, clr, rn);
      if (($urandom % 25) == 0) idle("rnd", $urandom_range(1, 6));
    end
    idle("end", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
